// File: rtl/status_led_engine.sv
// -----------------------------------------------------------------------------
// status_led_engine
//
// Multi-channel status-LED colour engine. NUM_CH asynchronous status bits are
// synchronised, shaped by a per-channel display mode (stretch, blink, toggle,
// off) and blended into NUM_LEDS RGB LEDs. Blending is a saturating
// per-component sum of the colours of every active channel mapped to an LED,
// followed by a global right-shift dim. All outputs are registered and feed
// 8-bit-per-colour PWM drivers.
//
// Ports
//   clk    in   1            sole clock
//   reset  in   1            synchronous, active-high reset
//   src    in   NUM_CH       asynchronous status bits, active high
//   mode   in   2*NUM_CH     per-channel mode, channel i at [2i+1:2i]
//                            (00 stretch, 01 blink, 10 toggle, 11 off)
//   dim    in   3            global brightness, each component >> dim
//   led_r  out  8*NUM_LEDS   red per LED, LED0 in [7:0]
//   led_g  out  8*NUM_LEDS   green per LED
//   led_b  out  8*NUM_LEDS   blue per LED
//
// Latency: src -> led_* is 4 edges (s1, s2, chan_on, led); mode -> led_* is
// 2 edges; dim -> led_* is 1 edge.
// -----------------------------------------------------------------------------
module status_led_engine #(
  parameter int          NUM_CH         = 4,
  parameter int          NUM_LEDS       = 2,
  parameter int          LED_IDX_W      = 1,
  // Untyped so an override of the wrong size can be caught at elaboration.
  parameter              CH_COLOUR      = 96'h000800_800000_000004_100000,
  parameter              CH_LED         = 4'b1100,
  parameter int unsigned STRETCH_CYCLES = 1000000,
  parameter int          STRETCH_W      = 20,
  parameter int          BLINK_W        = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     src,
  input  logic [2*NUM_CH-1:0]   mode,
  input  logic [2:0]            dim,
  output logic [8*NUM_LEDS-1:0] led_r,
  output logic [8*NUM_LEDS-1:0] led_g,
  output logic [8*NUM_LEDS-1:0] led_b
);

  typedef enum logic [1:0] {
    MODE_STRETCH = 2'b00,
    MODE_BLINK   = 2'b01,
    MODE_TOGGLE  = 2'b10,
    MODE_OFF     = 2'b11
  } mode_e;

  // 16 channels * 8'hFF = 4080 fits in 12 bits, so the sum never wraps
  // before saturation.
  localparam int SUM_W = 12;

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if ($bits(CH_COLOUR) != 24 * NUM_CH) begin : g_bad_colour
    $error("status_led_engine: CH_COLOUR must be 24*NUM_CH bits wide");
  end
  if ($bits(CH_LED) != LED_IDX_W * NUM_CH) begin : g_bad_led_map
    $error("status_led_engine: CH_LED must be LED_IDX_W*NUM_CH bits wide");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("status_led_engine: NUM_CH must be in 1..16");
  end
  if (NUM_LEDS < 1 || NUM_LEDS > 8) begin : g_bad_num_leds
    $error("status_led_engine: NUM_LEDS must be in 1..8");
  end
  if (LED_IDX_W < 1 || LED_IDX_W < $clog2(NUM_LEDS)) begin : g_bad_idx_w
    $error("status_led_engine: LED_IDX_W too narrow for NUM_LEDS");
  end
  if (STRETCH_W < 32 && 64'(STRETCH_CYCLES) >= (64'd1 << STRETCH_W)) begin : g_bad_stretch
    $error("status_led_engine: STRETCH_CYCLES does not fit in STRETCH_W bits");
  end

  localparam logic [24*NUM_CH-1:0]        COLOUR       = CH_COLOUR;
  localparam logic [LED_IDX_W*NUM_CH-1:0] LED_MAP      = CH_LED;
  localparam logic [STRETCH_W-1:0]        STRETCH_LOAD = STRETCH_W'(STRETCH_CYCLES);

  // ---------------------------------------------------------------------------
  // Shared state
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0]     s1_q, s2_q, s3_q;
  logic [BLINK_W-1:0]    blink_q;
  logic                  blink_phase;
  logic [NUM_CH-1:0]     chan_on_q, chan_on_d;
  logic [8*NUM_LEDS-1:0] led_r_q, led_g_q, led_b_q;
  logic [8*NUM_LEDS-1:0] led_r_d, led_g_d, led_b_d;

  assign blink_phase = blink_q[BLINK_W-1];

  // ---------------------------------------------------------------------------
  // Per-channel stretch counter, toggle bit and mode selection
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [STRETCH_W-1:0] cnt_q, cnt_d;
    logic                 tog_q, tog_d;
    logic                 str, rise, on_d;
    mode_e                ch_mode;

    assign ch_mode = mode_e'(mode[2*i +: 2]);
    assign str     = s2_q[i] | (cnt_q != '0);
    assign rise    = s2_q[i] & ~s3_q[i];

    // Reload while the level is high so the hold window counts from the
    // last sampled high cycle; a retrigger simply restarts the window.
    // NOTE: every variable gets a default at the top of an always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
      cnt_d = '0;
      if (s2_q[i]) begin
        cnt_d = STRETCH_LOAD;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    // tog defaults to 0, so any mode other than TOGGLE clears it and entering
    // TOGGLE always starts dark. chan_on takes the post-flip value so a rise
    // lights the channel with the same latency as the other modes.
    always_comb begin
      tog_d = 1'b0;
      on_d  = 1'b0;
      case (ch_mode)
        MODE_STRETCH: on_d = str;
        MODE_BLINK:   on_d = str & blink_phase;
        MODE_TOGGLE: begin
          tog_d = tog_q ^ rise;
          on_d  = tog_d;
        end
        default:      on_d = 1'b0;
      endcase
    end

    assign chan_on_d[i] = on_d;

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
        tog_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        tog_q <= tog_d;
      end
    end
  end : g_ch

  // ---------------------------------------------------------------------------
  // Blend: saturating per-component sum per LED, then dim shift
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] sat8(input logic [SUM_W-1:0] v);
    return (|v[SUM_W-1:8]) ? 8'hFF : v[7:0];
  endfunction

  // Channels whose LED index is >= NUM_LEDS never match any k and drop out.
  always_comb begin
    logic [SUM_W-1:0] acc_r, acc_g, acc_b;
    led_r_d = '0;
    led_g_d = '0;
    led_b_d = '0;
    for (int k = 0; k < NUM_LEDS; k++) begin
      acc_r = '0;
      acc_g = '0;
      acc_b = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (chan_on_q[i] && int'(LED_MAP[LED_IDX_W*i +: LED_IDX_W]) == k) begin
          acc_r = acc_r + SUM_W'(COLOUR[24*i+16 +: 8]);
          acc_g = acc_g + SUM_W'(COLOUR[24*i+8  +: 8]);
          acc_b = acc_b + SUM_W'(COLOUR[24*i    +: 8]);
        end
      end
      led_r_d[8*k +: 8] = sat8(acc_r) >> dim;
      led_g_d[8*k +: 8] = sat8(acc_g) >> dim;
      led_b_d[8*k +: 8] = sat8(acc_b) >> dim;
    end
  end

  // ---------------------------------------------------------------------------
  // Synchroniser, blink counter, channel enables and output registers
  // ---------------------------------------------------------------------------
  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples the pre-edge value of its source; blocking here would collapse
  // the s1/s2/s3 chain into a single stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      blink_q   <= '0;
      chan_on_q <= '0;
      led_r_q   <= '0;
      led_g_q   <= '0;
      led_b_q   <= '0;
    end else begin
      s1_q      <= src;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      blink_q   <= blink_q + 1'b1;
      chan_on_q <= chan_on_d;
      led_r_q   <= led_r_d;
      led_g_q   <= led_g_d;
      led_b_q   <= led_b_d;
    end
  end

  assign led_r = led_r_q;
  assign led_g = led_g_q;
  assign led_b = led_b_q;

endmodule : status_led_engine
